// File: rtl/chroma_pkg.sv
// chroma_pkg
//   Shared constants for the chroma-key controller slice: default widths,
//   register word addresses, CTRL bit positions, reset thresholds and the
//   calibration state encoding.
package chroma_pkg;

  localparam int DATA_W   = 10;
  localparam int CNT_W    = 20;
  localparam int CAL_LOG2 = 8;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_THR_G     = 3'd1;
  localparam logic [2:0] ADDR_THR_R     = 3'd2;
  localparam logic [2:0] ADDR_THR_B     = 3'd3;
  localparam logic [2:0] ADDR_STATUS    = 3'd4;
  localparam logic [2:0] ADDR_KEY_COUNT = 3'd5;
  localparam logic [2:0] ADDR_CAL_G     = 3'd6;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_COMMIT_BIT = 1;
  localparam int CTRL_CAL_BIT    = 2;

  localparam int unsigned RST_THR_G = 400;
  localparam int unsigned RST_THR_R = 100;
  localparam int unsigned RST_THR_B = 100;

  localparam logic [1:0] CAL_IDLE    = 2'd0;
  localparam logic [1:0] CAL_WAIT_FS = 2'd1;
  localparam logic [1:0] CAL_ACCUM   = 2'd2;
  localparam logic [1:0] CAL_DONE    = 2'd3;

endpackage

// File: rtl/chroma_calib.sv
// chroma_calib
//   One-shot key-colour calibration. After start it waits for a frame start,
//   then averages the green component of the next 2^CAL_LOG2 valid pixels.
//   A frame start during accumulation throws the partial sum away.
// Ports:
//   iCLK27, iRST     clock, asynchronous active-high reset
//   fs               frame-start pulse (one cycle)
//   iDataValid       active-pixel qualifier
//   iGreen           green component of the current pixel
//   start            calibration request (ignored while busy)
//   busy             calibration in progress
//   done             sticky: last calibration finished, cleared by start
//   result           calibrated mean green
module chroma_calib #(
  parameter int DATA_W   = chroma_pkg::DATA_W,
  parameter int CAL_LOG2 = chroma_pkg::CAL_LOG2
) (
  input  logic              iCLK27,
  input  logic              iRST,
  input  logic              fs,
  input  logic              iDataValid,
  input  logic [DATA_W-1:0] iGreen,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  import chroma_pkg::*;

  localparam int SUM_W = DATA_W + CAL_LOG2;
  localparam logic [CAL_LOG2:0] SAMPLES = {1'b1, {CAL_LOG2{1'b0}}};

  logic [1:0]          state;
  logic [SUM_W-1:0]    sum;
  logic [CAL_LOG2:0]   count;
  logic [CAL_LOG2:0]   count_next;

  assign busy       = (state != CAL_IDLE);
  assign count_next = count + (CAL_LOG2+1)'(1);

  // The sum is wide enough for 2^CAL_LOG2 full-scale samples, so the mean is
  // simply the top DATA_W bits of the sum.
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      state  <= CAL_IDLE;
      sum    <= '0;
      count  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        CAL_IDLE: begin
          if (start) begin
            state <= CAL_WAIT_FS;
            done  <= 1'b0;
          end
        end
        CAL_WAIT_FS: begin
          if (fs) begin
            state <= CAL_ACCUM;
            sum   <= '0;
            count <= '0;
          end
        end
        CAL_ACCUM: begin
          if (fs) begin
            sum   <= '0;
            count <= '0;
          end else if (iDataValid) begin
            sum   <= sum + SUM_W'(iGreen);
            count <= count_next;
            if (count_next == SAMPLES) state <= CAL_DONE;
          end
        end
        CAL_DONE: begin
          result <= sum[SUM_W-1:CAL_LOG2];
          done   <= 1'b1;
          state  <= CAL_IDLE;
        end
        default: state <= CAL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/chroma_key_ctrl.sv
// chroma_key_ctrl
//   Avalon-MM register front end for the chroma keyer. Holds staged
//   thresholds and key enable, commits them to the keyer at a frame start,
//   counts keyed pixels per frame and hosts the green calibration unit.
// Ports:
//   iCLK27, iRST                  clock, asynchronous active-high reset
//   iAddress/iWrite/iWriteData    bus write port (word addressed)
//   iRead/oReadData               bus read port, data one cycle after iRead
//   iVS                           vertical sync, rising edge = new frame
//   iDataValid/iKeyHit/iGreen     pixel qualifier, keyer decision, green
//   oThrG/oThrR/oThrB/oKeyEn      active keyer settings, frame-stable
module chroma_key_ctrl #(
  parameter int DATA_W   = chroma_pkg::DATA_W,
  parameter int CNT_W    = chroma_pkg::CNT_W,
  parameter int CAL_LOG2 = chroma_pkg::CAL_LOG2
) (
  input  logic              iCLK27,
  input  logic              iRST,
  input  logic [2:0]        iAddress,
  input  logic              iWrite,
  input  logic [31:0]       iWriteData,
  input  logic              iRead,
  output logic [31:0]       oReadData,
  input  logic              iVS,
  input  logic              iDataValid,
  input  logic              iKeyHit,
  input  logic [DATA_W-1:0] iGreen,
  output logic [DATA_W-1:0] oThrG,
  output logic [DATA_W-1:0] oThrR,
  output logic [DATA_W-1:0] oThrB,
  output logic              oKeyEn
);
  import chroma_pkg::*;

  localparam logic [DATA_W-1:0] THR_G_RST = DATA_W'(RST_THR_G);
  localparam logic [DATA_W-1:0] THR_R_RST = DATA_W'(RST_THR_R);
  localparam logic [DATA_W-1:0] THR_B_RST = DATA_W'(RST_THR_B);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic              vs_s;
  logic              vs_q;
  logic              fs;
  logic              wr_ctrl;
  logic              commit_req;
  logic              cal_start;
  logic              stage_en;
  logic [DATA_W-1:0] stage_g;
  logic [DATA_W-1:0] stage_r;
  logic [DATA_W-1:0] stage_b;
  logic              commit_pending;
  logic              key_hit;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  key_count;
  logic              cal_busy;
  logic              cal_done;
  logic [DATA_W-1:0] cal_g;
  logic [31:0]       rd_mux;
  logic              wdata_unused;

  assign wdata_unused = ^iWriteData[31:DATA_W];

  assign wr_ctrl    = iWrite && (iAddress == ADDR_CTRL);
  assign commit_req = wr_ctrl && iWriteData[CTRL_COMMIT_BIT];
  assign cal_start  = wr_ctrl && iWriteData[CTRL_CAL_BIT];
  assign key_hit    = iDataValid && iKeyHit;

  // iVS is registered once before edge detection, so fs is high in the cycle
  // after iVS rises and the commit lands on the second edge after the rise.
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      vs_s <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      vs_s <= iVS;
      vs_q <= vs_s;
    end
  end

  assign fs = vs_s && !vs_q;

  // Staged registers only; COMMIT and CAL_START are strobes, not storage.
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      stage_en <= 1'b1;
      stage_g  <= THR_G_RST;
      stage_r  <= THR_R_RST;
      stage_b  <= THR_B_RST;
    end else if (iWrite) begin
      case (iAddress)
        ADDR_CTRL:  stage_en <= iWriteData[CTRL_EN_BIT];
        ADDR_THR_G: stage_g  <= iWriteData[DATA_W-1:0];
        ADDR_THR_R: stage_r  <= iWriteData[DATA_W-1:0];
        ADDR_THR_B: stage_b  <= iWriteData[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  // A COMMIT arriving on the commit frame start re-arms pending, so it takes
  // effect one frame later. The copy uses pre-edge staged values, so a
  // staged write on that same cycle waits for the next commit.
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      commit_pending <= 1'b0;
      oKeyEn         <= 1'b1;
      oThrG          <= THR_G_RST;
      oThrR          <= THR_R_RST;
      oThrB          <= THR_B_RST;
    end else begin
      if (fs && commit_pending) begin
        oKeyEn <= stage_en;
        oThrG  <= stage_g;
        oThrR  <= stage_r;
        oThrB  <= stage_b;
      end
      if (commit_req) commit_pending <= 1'b1;
      else if (fs)    commit_pending <= 1'b0;
    end
  end

  // The frame-start cycle's own hit belongs to the new frame.
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      hit_cnt   <= '0;
      key_count <= '0;
    end else if (fs) begin
      key_count <= hit_cnt;
      hit_cnt   <= CNT_W'(key_hit);
    end else if (key_hit && (hit_cnt != CNT_MAX)) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

  chroma_calib #(
    .DATA_W   (DATA_W),
    .CAL_LOG2 (CAL_LOG2)
  ) u_calib (
    .iCLK27     (iCLK27),
    .iRST       (iRST),
    .fs         (fs),
    .iDataValid (iDataValid),
    .iGreen     (iGreen),
    .start      (cal_start),
    .busy       (cal_busy),
    .done       (cal_done),
    .result     (cal_g)
  );

  always_comb begin
    rd_mux = '0;
    case (iAddress)
      ADDR_CTRL:      rd_mux[0]            = stage_en;
      ADDR_THR_G:     rd_mux[DATA_W-1:0]   = stage_g;
      ADDR_THR_R:     rd_mux[DATA_W-1:0]   = stage_r;
      ADDR_THR_B:     rd_mux[DATA_W-1:0]   = stage_b;
      ADDR_STATUS:    rd_mux[2:0]          = {cal_done, cal_busy, commit_pending};
      ADDR_KEY_COUNT: rd_mux[CNT_W-1:0]    = key_count;
      ADDR_CAL_G:     rd_mux[DATA_W-1:0]   = cal_g;
      default:        rd_mux               = '0;
    endcase
  end

  // Read data is captured from pre-edge state, so a read and write to the
  // same address in one cycle returns the old contents.
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST)       oReadData <= '0;
    else if (iRead) oReadData <= rd_mux;
    else            oReadData <= '0;
  end

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// tb_chroma_key_ctrl
//   Randomised self-checking bench for chroma_key_ctrl. A register-level
//   model tracks staged/active settings, frame hit totals and calibration
//   averages; each scenario task compares DUT behaviour against it.
module tb_chroma_key_ctrl;

  localparam int DATA_W   = 10;
  localparam int CNT_W    = 10;
  localparam int CAL_LOG2 = 8;
  localparam int CAL_N    = 1 << CAL_LOG2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam logic [2:0] A_CTRL = 3'd0, A_THR_G = 3'd1, A_THR_R = 3'd2, A_THR_B = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4, A_KEY_COUNT = 3'd5, A_CAL_G = 3'd6, A_NONE = 3'd7;

  logic              iCLK27 = 1'b0;
  logic              iRST;
  logic [2:0]        iAddress;
  logic              iWrite;
  logic [31:0]       iWriteData;
  logic              iRead;
  logic [31:0]       oReadData;
  logic              iVS;
  logic              iDataValid;
  logic              iKeyHit;
  logic [DATA_W-1:0] iGreen;
  logic [DATA_W-1:0] oThrG, oThrR, oThrB;
  logic              oKeyEn;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] act_g, act_r, act_b, stg_g, stg_r, stg_b;
  logic              act_en, stg_en;
  logic              pending, cal_busy_m, cal_done_m;
  int                frame_hits, key_count_m, cal_g_m;

  chroma_key_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .CAL_LOG2(CAL_LOG2)) dut (
    .iCLK27(iCLK27), .iRST(iRST), .iAddress(iAddress), .iWrite(iWrite),
    .iWriteData(iWriteData), .iRead(iRead), .oReadData(oReadData), .iVS(iVS),
    .iDataValid(iDataValid), .iKeyHit(iKeyHit), .iGreen(iGreen),
    .oThrG(oThrG), .oThrR(oThrR), .oThrB(oThrB), .oKeyEn(oKeyEn)
  );

  always #5 iCLK27 = ~iCLK27;

  function automatic void model_reset();
    act_g = 10'd400; act_r = 10'd100; act_b = 10'd100; act_en = 1'b1;
    stg_g = 10'd400; stg_r = 10'd100; stg_b = 10'd100; stg_en = 1'b1;
    pending = 1'b0; cal_busy_m = 1'b0; cal_done_m = 1'b0;
    frame_hits = 0; key_count_m = 0; cal_g_m = 0;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      A_CTRL: begin
        stg_en = d[0];
        if (d[1]) pending = 1'b1;
        if (d[2] && !cal_busy_m) begin cal_busy_m = 1'b1; cal_done_m = 1'b0; end
      end
      A_THR_G: stg_g = d[DATA_W-1:0];
      A_THR_R: stg_r = d[DATA_W-1:0];
      A_THR_B: stg_b = d[DATA_W-1:0];
      default: ;
    endcase
  endfunction

  function automatic void model_fs();
    if (pending) begin
      act_g = stg_g; act_r = stg_r; act_b = stg_b; act_en = stg_en; pending = 1'b0;
    end
    key_count_m = (frame_hits > CNT_MAX) ? CNT_MAX : frame_hits;
    frame_hits  = 0;
  endfunction

  function automatic logic [31:0] status_m();
    return {29'd0, cal_done_m, cal_busy_m, pending};
  endfunction

  task automatic tick();
    @(posedge iCLK27); #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    iAddress = a; iWriteData = d; iWrite = 1'b1;
    tick();
    iWrite = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    iAddress = a; iRead = 1'b1;
    tick();
    d = oReadData;
    iRead = 1'b0;
  endtask

  task automatic drive_pixel(input logic v, input logic h, input logic [DATA_W-1:0] g);
    iDataValid = v; iKeyHit = h; iGreen = g;
    tick();
    if (v && h) frame_hits++;
    iDataValid = 1'b0; iKeyHit = 1'b0;
  endtask

  // iVS rise, then the frame-start cycle (optionally carrying a keyed pixel)
  task automatic vs_pulse(input logic fs_hit);
    iVS = 1'b1; iDataValid = 1'b0;
    tick();
    iDataValid = fs_hit; iKeyHit = fs_hit;
    tick();
    model_fs();
    if (fs_hit) frame_hits = 1;
    iDataValid = 1'b0; iKeyHit = 1'b0; iVS = 1'b0;
    tick(); tick();
  endtask

  task automatic fs_with_write(input logic [2:0] a, input logic [31:0] d);
    iVS = 1'b1;
    tick();
    iAddress = a; iWriteData = d; iWrite = 1'b1;
    tick();
    model_fs();
    model_write(a, d);
    iWrite = 1'b0; iVS = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    iRST = 1'b1; iAddress = '0; iWrite = 0; iWriteData = '0; iRead = 0;
    iVS = 0; iDataValid = 0; iKeyHit = 0; iGreen = '0;
    model_reset();
    repeat (3) tick();
    iRST = 1'b0;
    tick();
    checks++;
    if ({oKeyEn, oThrG, oThrR, oThrB} !== {act_en, act_g, act_r, act_b}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got en=%0d g=%0d r=%0d b=%0d expected en=1 g=400 r=100 b=100",
               oKeyEn, oThrG, oThrR, oThrB);
    end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_status: got %0h expected 0", rd); end
    bus_read(A_THR_G, rd);
    checks++;
    if (rd !== 32'd400) begin errors++; $display("[TB] FAIL reset_staged_g: got %0d expected 400", rd); end
    bus_read(A_KEY_COUNT, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_key_count: got %0d expected 0", rd); end
  endtask

  task automatic test_commit();
    logic [31:0] wd, rd;
    for (int n = 0; n < 3; n++) begin
      wd = $urandom; wd[DATA_W-1:0] = act_g ^ 10'($urandom_range(1, 1023)); bus_write(A_THR_G, wd);
      wd = $urandom; wd[DATA_W-1:0] = act_r ^ 10'($urandom_range(1, 1023)); bus_write(A_THR_R, wd);
      wd = $urandom; wd[DATA_W-1:0] = act_b ^ 10'($urandom_range(1, 1023)); bus_write(A_THR_B, wd);
      bus_write(A_CTRL, {30'd0, 1'b1, 1'($urandom_range(0, 1))});
      repeat (5) tick();
      checks++;
      if ({oKeyEn, oThrG, oThrR, oThrB} !== {act_en, act_g, act_r, act_b}) begin
        errors++; $display("[TB] FAIL commit_hold_midframe: got g=%0d expected g=%0d", oThrG, act_g);
      end
      bus_read(A_STATUS, rd);
      checks++;
      if (rd !== status_m()) begin errors++; $display("[TB] FAIL commit_pending_set: got %0h expected %0h", rd, status_m()); end
      iVS = 1'b1;
      tick();
      checks++;
      if ({oKeyEn, oThrG, oThrR, oThrB} !== {act_en, act_g, act_r, act_b}) begin
        errors++; $display("[TB] FAIL commit_edge1_early: got g=%0d expected g=%0d", oThrG, act_g);
      end
      tick();
      model_fs();
      checks++;
      if ({oKeyEn, oThrG, oThrR, oThrB} !== {act_en, act_g, act_r, act_b}) begin
        errors++; $display("[TB] FAIL commit_edge2_load: got en=%0d g=%0d r=%0d b=%0d expected en=%0d g=%0d r=%0d b=%0d",
                           oKeyEn, oThrG, oThrR, oThrB, act_en, act_g, act_r, act_b);
      end
      iVS = 1'b0; tick(); tick();
      bus_read(A_STATUS, rd);
      checks++;
      if (rd !== status_m()) begin errors++; $display("[TB] FAIL commit_pending_clear: got %0h expected %0h", rd, status_m()); end
    end
  endtask

  task automatic test_commit_on_fs();
    logic [31:0] rd;
    logic [DATA_W-1:0] x, y;
    bus_write(A_THR_G, 32'(act_g ^ 10'h155));
    fs_with_write(A_CTRL, {30'd0, 1'b1, stg_en});
    checks++;
    if (oThrG !== act_g) begin errors++; $display("[TB] FAIL fs_commit_deferred: got %0d expected %0d", oThrG, act_g); end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== status_m()) begin errors++; $display("[TB] FAIL fs_commit_pending: got %0h expected %0h", rd, status_m()); end
    vs_pulse(1'b0);
    checks++;
    if (oThrG !== act_g) begin errors++; $display("[TB] FAIL fs_commit_next_frame: got %0d expected %0d", oThrG, act_g); end
    x = 10'($urandom_range(0, 1023));
    y = x ^ 10'($urandom_range(1, 1023));
    bus_write(A_THR_G, 32'(x));
    bus_write(A_CTRL, {30'd0, 1'b1, stg_en});
    fs_with_write(A_THR_G, 32'(y));
    checks++;
    if (oThrG !== act_g) begin errors++; $display("[TB] FAIL fs_write_excluded: got %0d expected %0d", oThrG, act_g); end
    bus_read(A_THR_G, rd);
    checks++;
    if (rd !== 32'(stg_g)) begin errors++; $display("[TB] FAIL fs_write_staged: got %0d expected %0d", rd, stg_g); end
  endtask

  task automatic test_key_count();
    logic [31:0] rd;
    vs_pulse(1'b0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) drive_pixel(1'b0, 1'b1, '0);
      drive_pixel(1'b1, 1'($urandom_range(0, 3) == 0), '0);
    end
    vs_pulse(1'b1);
    bus_read(A_KEY_COUNT, rd);
    checks++;
    if (rd !== 32'(key_count_m)) begin errors++; $display("[TB] FAIL key_count_frame: got %0d expected %0d", rd, key_count_m); end
    for (int i = 0; i < CNT_MAX + 6; i++) drive_pixel(1'b1, 1'b1, '0);
    vs_pulse(1'b0);
    bus_read(A_KEY_COUNT, rd);
    checks++;
    if (rd !== 32'(CNT_MAX)) begin errors++; $display("[TB] FAIL key_count_saturate: got %0d expected %0d", rd, CNT_MAX); end
    for (int i = 0; i < 40; i++) drive_pixel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0);
    vs_pulse(1'b0);
    bus_read(A_KEY_COUNT, rd);
    checks++;
    if (rd !== 32'(key_count_m)) begin errors++; $display("[TB] FAIL key_count_after_sat: got %0d expected %0d", rd, key_count_m); end
  endtask

  task automatic test_calibration();
    logic [31:0] rd;
    int sum;
    logic [DATA_W-1:0] g;
    // Run 1: random greens, with a CAL_START mid-run that must be ignored
    bus_write(A_CTRL, {29'd0, 1'b1, 1'b0, stg_en});
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== status_m()) begin errors++; $display("[TB] FAIL cal_busy_start: got %0h expected %0h", rd, status_m()); end
    vs_pulse(1'b0);
    sum = 0;
    for (int i = 0; i < CAL_N; i++) begin
      if ($urandom_range(0, 3) == 0) drive_pixel(1'b0, 1'b0, 10'($urandom));
      if (i == CAL_N / 2) bus_write(A_CTRL, {29'd0, 1'b1, 1'b0, stg_en});
      g = 10'($urandom);
      sum += int'(g);
      drive_pixel(1'b1, 1'b0, g);
    end
    tick();
    cal_busy_m = 1'b0; cal_done_m = 1'b1; cal_g_m = sum / CAL_N;
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== status_m()) begin errors++; $display("[TB] FAIL cal_done_status: got %0h expected %0h", rd, status_m()); end
    bus_read(A_CAL_G, rd);
    checks++;
    if (rd !== 32'(cal_g_m)) begin errors++; $display("[TB] FAIL cal_mean_random: got %0d expected %0d", rd, cal_g_m); end
    // Run 2: frame start after 100 pixels discards them
    bus_write(A_CTRL, {29'd0, 1'b1, 1'b0, stg_en});
    vs_pulse(1'b0);
    for (int i = 0; i < 100; i++) drive_pixel(1'b1, 1'b0, 10'd1023);
    vs_pulse(1'b0);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== status_m()) begin errors++; $display("[TB] FAIL cal_restart_busy: got %0h expected %0h", rd, status_m()); end
    for (int i = 0; i < CAL_N; i++) drive_pixel(1'b1, 1'b0, 10'd600);
    tick();
    cal_busy_m = 1'b0; cal_done_m = 1'b1; cal_g_m = 600;
    bus_read(A_CAL_G, rd);
    checks++;
    if (rd !== 32'(cal_g_m)) begin errors++; $display("[TB] FAIL cal_mean_restart: got %0d expected %0d", rd, cal_g_m); end
  endtask

  task automatic test_bus_misc();
    logic [31:0] rd, old_b;
    logic [DATA_W-1:0] nb;
    for (int i = 0; i < 37; i++) drive_pixel(1'b1, 1'($urandom_range(0, 1)), '0);
    vs_pulse(1'b0);
    bus_read(A_NONE, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL read_addr7: got %0h expected 0", rd); end
    bus_write(A_KEY_COUNT, $urandom);
    bus_read(A_KEY_COUNT, rd);
    checks++;
    if (rd !== 32'(key_count_m)) begin errors++; $display("[TB] FAIL key_count_ro: got %0d expected %0d", rd, key_count_m); end
    bus_write(A_CAL_G, $urandom);
    bus_read(A_CAL_G, rd);
    checks++;
    if (rd !== 32'(cal_g_m)) begin errors++; $display("[TB] FAIL cal_g_ro: got %0d expected %0d", rd, cal_g_m); end
    bus_write(A_STATUS, 32'hFFFF_FFFF);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== status_m()) begin errors++; $display("[TB] FAIL status_ro: got %0h expected %0h", rd, status_m()); end
    old_b = 32'(stg_b);
    nb = stg_b ^ 10'($urandom_range(1, 1023));
    iAddress = A_THR_B; iWriteData = {22'h3FFFFF, nb}; iWrite = 1'b1; iRead = 1'b1;
    tick();
    rd = oReadData;
    iWrite = 1'b0; iRead = 1'b0;
    model_write(A_THR_B, {22'h3FFFFF, nb});
    checks++;
    if (rd !== old_b) begin errors++; $display("[TB] FAIL read_during_write: got %0d expected %0d", rd, old_b); end
    bus_read(A_THR_B, rd);
    checks++;
    if (rd !== 32'(stg_b)) begin errors++; $display("[TB] FAIL write_upper_ignored: got %0h expected %0h", rd, stg_b); end
    bus_write(A_CTRL, 32'd0);
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== {31'd0, stg_en}) begin errors++; $display("[TB] FAIL ctrl_readback: got %0h expected %0h", rd, stg_en); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    bus_write(A_THR_G, 32'd77);
    bus_write(A_CTRL, 32'h2);
    vs_pulse(1'b0);
    bus_write(A_CTRL, {29'd0, 1'b1, 1'b0, stg_en});
    vs_pulse(1'b0);
    bus_write(A_THR_R, 32'd55);
    bus_write(A_CTRL, {30'd0, 1'b1, stg_en});
    for (int i = 0; i < 50; i++) drive_pixel(1'b1, 1'b1, 10'($urandom));
    @(posedge iCLK27); #3;
    iRST = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({oKeyEn, oThrG, oThrR, oThrB} !== {act_en, act_g, act_r, act_b}) begin
      errors++; $display("[TB] FAIL async_reset_outputs: got en=%0d g=%0d r=%0d b=%0d expected en=1 g=400 r=100 b=100",
                         oKeyEn, oThrG, oThrR, oThrB);
    end
    #1;
    iRST = 1'b0;
    tick();
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_aborts_status: got %0h expected 0", rd); end
    vs_pulse(1'b0);
    checks++;
    if ({oKeyEn, oThrG, oThrR, oThrB} !== {act_en, act_g, act_r, act_b}) begin
      errors++; $display("[TB] FAIL reset_no_commit: got g=%0d r=%0d expected g=%0d r=%0d", oThrG, oThrR, act_g, act_r);
    end
    bus_read(A_THR_R, rd);
    checks++;
    if (rd !== 32'd100) begin errors++; $display("[TB] FAIL reset_staged_r: got %0d expected 100", rd); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_commit_on_fs();
    test_key_count();
    test_calibration();
    test_bus_misc();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
